ahb2_master_arb: RTL and testbench

- Two-master AHB-Lite arbiter that sits directly upstream of the AHB-Lite system block. It merges the CPU data port (M0) and the instruction/fetch port (M1) into the single master port that drives the system's HADDR/HTRANS/HWRITE/HSIZE/HWDATA and consumes its HREADY/HRDATA.
- A losing or blocked request is captured in a per-master hold slot. That master is stalled through its own HREADY until the hold slot is serviced, so no write-data buffering is needed.

---
 rtl/ahb_arb_pkg.sv | 27 ++
 rtl/ahb_req_hold.sv | 37 +++
 rtl/ahb2_master_arb.sv | 149 ++++++++++++++
 tb/tb_ahb2_master_arb.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_arb_pkg.sv
// Shared definitions for the two-master AHB-Lite arbiter: transfer types, master indices and the
// address/control record held in each master's hold slot.
package ahb_arb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // Widest address the hold record carries; the top's AW must not exceed it.
  localparam int unsigned REQ_AW = 32;

  typedef struct packed {
    logic [REQ_AW-1:0] addr;
    logic              write;
    logic [2:0]        size;
  } ahb_req_t;

  // BUSY is deliberately treated like IDLE: only NONSEQ/SEQ start a transfer.
  function automatic logic is_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_req_hold.sv
// Per-master hold slot: parks one address-phase request and presents either the parked request
// or the live one as this master's arbitration candidate.
module ahb_req_hold
  import ahb_arb_pkg::*;
(
  input  logic     i_clk,
  input  logic     i_rst,
  input  logic     i_capture,
  input  logic     i_clear,
  input  logic     i_live_valid,
  input  ahb_req_t i_live,
  output logic     o_hold_valid,
  output logic     o_cand_valid,
  output ahb_req_t o_cand
);

  logic     r_valid;
  ahb_req_t r_req;

  // Capture and clear never coincide: a live request only exists while the slot is empty.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_req   <= '0;
    end else if (i_capture) begin
      r_valid <= 1'b1;
      r_req   <= i_live;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  assign o_hold_valid = r_valid;
  assign o_cand_valid = r_valid | i_live_valid;
  assign o_cand       = r_valid ? r_req : i_live;

endmodule

// File: rtl/ahb2_master_arb.sv
// Two-master AHB-Lite arbiter: merges the CPU data port (M0) and fetch port (M1) onto a single
// downstream master port; a losing or blocked request waits in its master's hold slot.
module ahb2_master_arb
  import ahb_arb_pkg::*;
#(
  parameter int unsigned RR = 0,
  parameter int unsigned AW = 32
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic [AW-1:0] M0_HADDR,
  input  logic [1:0]    M0_HTRANS,
  input  logic          M0_HWRITE,
  input  logic [2:0]    M0_HSIZE,
  input  logic [31:0]   M0_HWDATA,
  output logic          M0_HREADY,
  output logic [31:0]   M0_HRDATA,
  input  logic [AW-1:0] M1_HADDR,
  input  logic [1:0]    M1_HTRANS,
  input  logic          M1_HWRITE,
  input  logic [2:0]    M1_HSIZE,
  input  logic [31:0]   M1_HWDATA,
  output logic          M1_HREADY,
  output logic [31:0]   M1_HRDATA,
  output logic [AW-1:0] HADDR,
  output logic [1:0]    HTRANS,
  output logic          HWRITE,
  output logic [2:0]    HSIZE,
  output logic [31:0]   HWDATA,
  input  logic          HREADY,
  input  logic [31:0]   HRDATA
);

  logic [1:0] w_mready;
  logic [1:0] w_live;
  logic [1:0] w_capture;
  logic [1:0] w_clear;
  logic [1:0] w_hold_valid;
  logic [1:0] w_cand_valid;
  ahb_req_t   w_req  [2];
  ahb_req_t   w_cand [2];
  ahb_req_t   w_sel;
  logic       w_gnt_valid;
  logic       w_gnt;
  logic       w_accept;

  logic       r_stall;
  logic       r_last_win;
  logic       r_rr_last;
  logic       r_dp_valid;
  logic       r_dp_owner;

  // A master is stalled while its request is parked, or while its own data phase is stretched.
  assign w_mready[0] = ~w_hold_valid[0] & ~(r_dp_valid & (r_dp_owner == M0) & ~HREADY);
  assign w_mready[1] = ~w_hold_valid[1] & ~(r_dp_valid & (r_dp_owner == M1) & ~HREADY);
  assign M0_HREADY   = w_mready[0];
  assign M1_HREADY   = w_mready[1];

  assign w_live[0] = is_active(M0_HTRANS) & w_mready[0];
  assign w_live[1] = is_active(M1_HTRANS) & w_mready[1];

  assign w_req[0] = '{addr: REQ_AW'(M0_HADDR), write: M0_HWRITE, size: M0_HSIZE};
  assign w_req[1] = '{addr: REQ_AW'(M1_HADDR), write: M1_HWRITE, size: M1_HSIZE};

  ahb_req_hold u_hold_m0 (
    .i_clk        (HCLK),
    .i_rst        (HRESETn),
    .i_capture    (w_capture[0]),
    .i_clear      (w_clear[0]),
    .i_live_valid (w_live[0]),
    .i_live       (w_req[0]),
    .o_hold_valid (w_hold_valid[0]),
    .o_cand_valid (w_cand_valid[0]),
    .o_cand       (w_cand[0])
  );

  ahb_req_hold u_hold_m1 (
    .i_clk        (HCLK),
    .i_rst        (HRESETn),
    .i_capture    (w_capture[1]),
    .i_clear      (w_clear[1]),
    .i_live_valid (w_live[1]),
    .i_live       (w_req[1]),
    .o_hold_valid (w_hold_valid[1]),
    .o_cand_valid (w_cand_valid[1]),
    .o_cand       (w_cand[1])
  );

  // While the downstream stretches an address phase the grant is frozen; the frozen winner
  // always sits in its hold slot, so its candidate stays valid and stable.
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt       = M0;
    if (r_stall) begin
      w_gnt_valid = 1'b1;
      w_gnt       = r_last_win;
    end else if (w_cand_valid[0] && w_cand_valid[1]) begin
      w_gnt_valid = 1'b1;
      w_gnt       = ((RR != 0) && (r_rr_last == M0)) ? M1 : M0;
    end else if (w_cand_valid[0]) begin
      w_gnt_valid = 1'b1;
      w_gnt       = M0;
    end else if (w_cand_valid[1]) begin
      w_gnt_valid = 1'b1;
      w_gnt       = M1;
    end
  end

  assign w_accept = w_gnt_valid & HREADY;

  // Anything live that does not leave this cycle is parked, including a live winner under
  // HREADY=0 so the frozen output is driven from the slot afterwards.
  assign w_capture[0] = w_live[0] & ~(w_accept & (w_gnt == M0));
  assign w_capture[1] = w_live[1] & ~(w_accept & (w_gnt == M1));
  assign w_clear[0]   = w_hold_valid[0] & w_accept & (w_gnt == M0);
  assign w_clear[1]   = w_hold_valid[1] & w_accept & (w_gnt == M1);

  assign w_sel  = (w_gnt == M1) ? w_cand[1] : w_cand[0];
  assign HTRANS = w_gnt_valid ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR  = w_gnt_valid ? AW'(w_sel.addr) : '0;
  assign HWRITE = w_gnt_valid & w_sel.write;
  assign HSIZE  = w_gnt_valid ? w_sel.size : 3'b000;

  // The data-phase owner is stretched through its HREADY, so its live HWDATA is still valid.
  assign HWDATA    = (r_dp_owner == M1) ? M1_HWDATA : M0_HWDATA;
  assign M0_HRDATA = HRDATA;
  assign M1_HRDATA = HRDATA;

  always_ff @(posedge HCLK) begin
    if (HRESETn) begin
      r_stall    <= 1'b0;
      r_last_win <= M0;
      r_rr_last  <= M1;
      r_dp_valid <= 1'b0;
      r_dp_owner <= M0;
    end else begin
      r_stall    <= w_gnt_valid & ~HREADY;
      r_last_win <= w_gnt;
      if (HREADY) begin
        r_dp_valid <= w_gnt_valid;
        r_dp_owner <= w_gnt;
        if (w_gnt_valid) begin
          r_rr_last <= w_gnt;
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb2_master_arb.sv
// Bench for ahb2_master_arb: directed scenarios plus randomized traffic on a fixed-priority and
// a round-robin instance, both checked against a queue-based transaction model.
module tb_ahb2_master_arb;

  logic        HCLK;
  logic        HRESETn;
  logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata, hrdata;
  logic [1:0]  m0_htrans, m1_htrans;
  logic        m0_hwrite, m1_hwrite, hready;
  logic [2:0]  m0_hsize, m1_hsize;

  logic [31:0] o_haddr     [2];
  logic [1:0]  o_htrans    [2];
  logic        o_hwrite    [2];
  logic [2:0]  o_hsize     [2];
  logic [31:0] o_hwdata    [2];
  logic        o_m0_hready [2];
  logic        o_m1_hready [2];
  logic [31:0] o_m0_hrdata [2];
  logic [31:0] o_m1_hrdata [2];

  int n_cmp = 0;
  int n_err = 0;

  ahb2_master_arb #(.RR(0), .AW(32)) u_dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M0_HADDR(m0_haddr), .M0_HTRANS(m0_htrans), .M0_HWRITE(m0_hwrite), .M0_HSIZE(m0_hsize),
    .M0_HWDATA(m0_hwdata), .M0_HREADY(o_m0_hready[0]), .M0_HRDATA(o_m0_hrdata[0]),
    .M1_HADDR(m1_haddr), .M1_HTRANS(m1_htrans), .M1_HWRITE(m1_hwrite), .M1_HSIZE(m1_hsize),
    .M1_HWDATA(m1_hwdata), .M1_HREADY(o_m1_hready[0]), .M1_HRDATA(o_m1_hrdata[0]),
    .HADDR(o_haddr[0]), .HTRANS(o_htrans[0]), .HWRITE(o_hwrite[0]), .HSIZE(o_hsize[0]),
    .HWDATA(o_hwdata[0]), .HREADY(hready), .HRDATA(hrdata)
  );

  ahb2_master_arb #(.RR(1), .AW(32)) u_dut1 (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .M0_HADDR(m0_haddr), .M0_HTRANS(m0_htrans), .M0_HWRITE(m0_hwrite), .M0_HSIZE(m0_hsize),
    .M0_HWDATA(m0_hwdata), .M0_HREADY(o_m0_hready[1]), .M0_HRDATA(o_m0_hrdata[1]),
    .M1_HADDR(m1_haddr), .M1_HTRANS(m1_htrans), .M1_HWRITE(m1_hwrite), .M1_HSIZE(m1_hsize),
    .M1_HWDATA(m1_hwdata), .M1_HREADY(o_m1_hready[1]), .M1_HRDATA(o_m1_hrdata[1]),
    .HADDR(o_haddr[1]), .HTRANS(o_htrans[1]), .HWRITE(o_hwrite[1]), .HSIZE(o_hsize[1]),
    .HWDATA(o_hwdata[1]), .HREADY(hready), .HRDATA(hrdata)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Reference model: per instance, a queue of accepted-but-not-issued transfers per master and
  // a queue holding the master whose data phase is in progress.
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
  } tb_req_t;

  typedef struct {
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic        rdy0;
    logic        rdy1;
    bit          hwdata_chk;
    logic [31:0] hwdata;
  } exp_t;

  tb_req_t pend [2][2][$];
  int      dq   [2][$];
  int      last_win [2];
  bit      frozen   [2];
  int      frozen_m [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      pend[k][0].delete();
      pend[k][1].delete();
      dq[k].delete();
      last_win[k] = 1;
      frozen[k]   = 1'b0;
      frozen_m[k] = 0;
    end
  endtask

  task automatic model_cycle(input int k, output exp_t e);
    tb_req_t    live [2];
    logic [1:0] tr   [2];
    bit         rdy  [2];
    bit         gv;
    int         win;
    live[0].addr = m0_haddr; live[0].write = m0_hwrite; live[0].size = m0_hsize;
    live[1].addr = m1_haddr; live[1].write = m1_hwrite; live[1].size = m1_hsize;
    tr[0] = m0_htrans;
    tr[1] = m1_htrans;
    e.hwdata_chk = (dq[k].size() != 0);
    e.hwdata     = (dq[k].size() != 0 && dq[k][0] == 1) ? m1_hwdata : m0_hwdata;
    for (int m = 0; m < 2; m++)
      rdy[m] = (pend[k][m].size() == 0) && !(dq[k].size() != 0 && dq[k][0] == m && !hready);
    e.rdy0 = rdy[0];
    e.rdy1 = rdy[1];
    for (int m = 0; m < 2; m++)
      if (tr[m][1] && rdy[m]) pend[k][m].push_back(live[m]);
    gv  = 1'b0;
    win = 0;
    if (frozen[k]) begin
      win = frozen_m[k];
      gv  = (pend[k][win].size() != 0);
    end else if (pend[k][0].size() != 0 && pend[k][1].size() != 0) begin
      gv  = 1'b1;
      win = (k == 1 && last_win[k] == 0) ? 1 : 0;
    end else if (pend[k][0].size() != 0) begin
      gv = 1'b1; win = 0;
    end else if (pend[k][1].size() != 0) begin
      gv = 1'b1; win = 1;
    end
    e.htrans = gv ? 2'b10 : 2'b00;
    e.haddr  = gv ? pend[k][win][0].addr  : 32'h0;
    e.hwrite = gv ? pend[k][win][0].write : 1'b0;
    e.hsize  = gv ? pend[k][win][0].size  : 3'b000;
    if (hready) begin
      dq[k].delete();
      if (gv) begin
        void'(pend[k][win].pop_front());
        last_win[k] = win;
        dq[k].push_back(win);
      end
    end
    frozen[k]   = gv && !hready;
    frozen_m[k] = win;
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_inputs();
    m0_htrans = 2'b00; m0_haddr = '0; m0_hwrite = 1'b0; m0_hsize = 3'd0; m0_hwdata = '0;
    m1_htrans = 2'b00; m1_haddr = '0; m1_hwrite = 1'b0; m1_hsize = 3'd0; m1_hwdata = '0;
  endtask

  task automatic do_reset();
    HRESETn = 1'b1;
    idle_inputs();
    hready = 1'b1;
    hrdata = '0;
    step();
    step();
    HRESETn = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (o_htrans[k] !== 2'b00) begin n_err++;
        $display("FAIL reset_htrans[%0d]: got %h want 0", k, o_htrans[k]); end
      n_cmp++; if (o_haddr[k] !== 32'h0 || o_hwrite[k] !== 1'b0 || o_hsize[k] !== 3'd0) begin
        n_err++; $display("FAIL reset_ctrl[%0d]: got %h/%b/%h want 0", k, o_haddr[k],
                          o_hwrite[k], o_hsize[k]); end
      n_cmp++; if (o_m0_hready[k] !== 1'b1 || o_m1_hready[k] !== 1'b1) begin n_err++;
        $display("FAIL reset_hready[%0d]: got %b%b want 11", k, o_m0_hready[k],
                 o_m1_hready[k]); end
    end
  endtask

  task automatic test_single();
    do_reset();
    m0_htrans = 2'b10; m0_haddr = 32'h2000_0004; m0_hsize = 3'd2;
    #1;
    n_cmp++; if (o_haddr[0] !== 32'h2000_0004) begin n_err++;
      $display("FAIL single_haddr: got %h want 20000004", o_haddr[0]); end
    n_cmp++; if (o_htrans[0] !== 2'b10 || o_hsize[0] !== 3'd2) begin n_err++;
      $display("FAIL single_ctrl: got %h/%h want 2/2", o_htrans[0], o_hsize[0]); end
    step();
    idle_inputs();
    hrdata = 32'h1234_5678;
    #1;
    n_cmp++; if (o_m0_hrdata[0] !== 32'h1234_5678 || o_m0_hready[0] !== 1'b1) begin n_err++;
      $display("FAIL single_rdata: got %h/%b want 12345678/1", o_m0_hrdata[0],
               o_m0_hready[0]); end
    n_cmp++; if (o_htrans[0] !== 2'b00) begin n_err++;
      $display("FAIL single_idle: got %h want 0", o_htrans[0]); end
  endtask

  task automatic test_collision();
    do_reset();
    m0_htrans = 2'b10; m0_haddr = 32'h4000_0000; m0_hwrite = 1'b1; m0_hsize = 3'd2;
    m1_htrans = 2'b10; m1_haddr = 32'h0000_0100; m1_hwrite = 1'b0; m1_hsize = 3'd2;
    #1;
    n_cmp++; if (o_haddr[0] !== 32'h4000_0000 || o_hwrite[0] !== 1'b1) begin n_err++;
      $display("FAIL coll_first: got %h/%b want 40000000/1", o_haddr[0], o_hwrite[0]); end
    step();
    idle_inputs();
    m0_hwdata = 32'hA5A5_0001;
    #1;
    n_cmp++; if (o_m1_hready[0] !== 1'b0) begin n_err++;
      $display("FAIL coll_m1_stall: got %b want 0", o_m1_hready[0]); end
    n_cmp++; if (o_haddr[0] !== 32'h0000_0100 || o_htrans[0] !== 2'b10 || o_hwrite[0] !== 1'b0)
      begin n_err++; $display("FAIL coll_from_hold: got %h/%h/%b want 00000100/2/0",
                              o_haddr[0], o_htrans[0], o_hwrite[0]); end
    n_cmp++; if (o_hwdata[0] !== 32'hA5A5_0001) begin n_err++;
      $display("FAIL coll_hwdata: got %h want a5a50001", o_hwdata[0]); end
    step();
    hready = 1'b0;
    #1;
    n_cmp++; if (o_m1_hready[0] !== 1'b0 || o_htrans[0] !== 2'b00) begin n_err++;
      $display("FAIL coll_follow0: got %b/%h want 0/0", o_m1_hready[0], o_htrans[0]); end
    hready = 1'b1;
    #1;
    n_cmp++; if (o_m1_hready[0] !== 1'b1) begin n_err++;
      $display("FAIL coll_follow1: got %b want 1", o_m1_hready[0]); end
    step();
  endtask

  task automatic test_rr_alternate();
    logic b0, b1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      m0_htrans = 2'b10; m0_haddr = 32'h0000_1000 + 32'(i * 4);
      m1_htrans = 2'b10; m1_haddr = 32'h8000_0000 + 32'(i * 4);
      #1;
      b0 = o_haddr[0][31];
      b1 = o_haddr[1][31];
      n_cmp++; if (b1 !== 1'(i % 2) || o_htrans[1] !== 2'b10) begin n_err++;
        $display("FAIL rr_alt[%0d]: got master %b want %0d", i, b1, i % 2); end
      n_cmp++; if (b0 !== 1'b0) begin n_err++;
        $display("FAIL fixed_prio[%0d]: got master %b want 0", i, b0); end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_stall();
    do_reset();
    m1_htrans = 2'b10; m1_haddr = 32'h0000_0200; m1_hsize = 3'd1;
    hready = 1'b0;
    #1;
    n_cmp++; if (o_haddr[0] !== 32'h200 || o_htrans[0] !== 2'b10) begin n_err++;
      $display("FAIL stall_c0: got %h/%h want 200/2", o_haddr[0], o_htrans[0]); end
    for (int c = 1; c < 3; c++) begin
      step();
      m1_haddr = $urandom;
      #1;
      n_cmp++; if (o_haddr[0] !== 32'h200 || o_htrans[0] !== 2'b10 || o_hsize[0] !== 3'd1)
        begin n_err++; $display("FAIL stall_c%0d: got %h/%h/%h want 200/2/1", c, o_haddr[0],
                                o_htrans[0], o_hsize[0]); end
      n_cmp++; if (o_m1_hready[0] !== 1'b0) begin n_err++;
        $display("FAIL stall_m1rdy_c%0d: got %b want 0", c, o_m1_hready[0]); end
    end
    step();
    hready = 1'b1;
    m1_htrans = 2'b00;
    #1;
    n_cmp++; if (o_haddr[0] !== 32'h200 || o_htrans[0] !== 2'b10) begin n_err++;
      $display("FAIL stall_release: got %h/%h want 200/2", o_haddr[0], o_htrans[0]); end
    step();
    #1;
    n_cmp++; if (o_htrans[0] !== 2'b00 || o_m1_hready[0] !== 1'b1) begin n_err++;
      $display("FAIL stall_cleared: got %h/%b want 0/1", o_htrans[0], o_m1_hready[0]); end
  endtask

  task automatic test_wdata();
    do_reset();
    m0_htrans = 2'b10; m0_haddr = 32'h0000_0300;
    m1_htrans = 2'b10; m1_haddr = 32'h0000_0500; m1_hwrite = 1'b1; m1_hsize = 3'd2;
    step();
    idle_inputs();
    #1;
    n_cmp++; if (o_m1_hready[0] !== 1'b0 || o_haddr[0] !== 32'h500 || o_hwrite[0] !== 1'b1)
      begin n_err++; $display("FAIL wdata_addr: got %b/%h/%b want 0/500/1", o_m1_hready[0],
                              o_haddr[0], o_hwrite[0]); end
    step();
    m1_hwdata = 32'hDEAD_BEEF;
    hready = 1'b0;
    #1;
    n_cmp++; if (o_hwdata[0] !== 32'hDEAD_BEEF || o_m1_hready[0] !== 1'b0) begin n_err++;
      $display("FAIL wdata_stretch: got %h/%b want deadbeef/0", o_hwdata[0],
               o_m1_hready[0]); end
    step();
    hready = 1'b1;
    #1;
    n_cmp++; if (o_hwdata[0] !== 32'hDEAD_BEEF || o_m1_hready[0] !== 1'b1) begin n_err++;
      $display("FAIL wdata_done: got %h/%b want deadbeef/1", o_hwdata[0], o_m1_hready[0]); end
    step();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    m0_htrans = 2'b10; m0_haddr = 32'h0000_0040;
    m1_htrans = 2'b10; m1_haddr = 32'h0000_0080;
    step();
    idle_inputs();
    hready  = 1'b0;
    HRESETn = 1'b1;
    #1;
    n_cmp++; if (o_m1_hready[0] !== 1'b0 || o_m0_hready[0] !== 1'b0) begin n_err++;
      $display("FAIL pre_reset_busy: got %b%b want 00", o_m0_hready[0], o_m1_hready[0]); end
    step();
    HRESETn = 1'b0;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (o_htrans[k] !== 2'b00 || o_haddr[k] !== 32'h0) begin n_err++;
        $display("FAIL midrst_out[%0d]: got %h/%h want 0/0", k, o_htrans[k], o_haddr[k]); end
      n_cmp++; if (o_m0_hready[k] !== 1'b1 || o_m1_hready[k] !== 1'b1) begin n_err++;
        $display("FAIL midrst_rdy[%0d]: got %b%b want 11", k, o_m0_hready[k],
                 o_m1_hready[k]); end
    end
    hready = 1'b1;
    step();
  endtask

  task automatic rand_inputs();
    m0_htrans = 2'($urandom_range(0, 3)); m0_haddr = $urandom; m0_hwrite = 1'($urandom);
    m0_hsize  = 3'($urandom_range(0, 2)); m0_hwdata = $urandom;
    m1_htrans = 2'($urandom_range(0, 3)); m1_haddr = $urandom; m1_hwrite = 1'($urandom);
    m1_hsize  = 3'($urandom_range(0, 2)); m1_hwdata = $urandom;
    hready    = ($urandom_range(0, 3) != 0);
    hrdata    = $urandom;
  endtask

  task automatic test_random();
    exp_t e;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rand_inputs();
      if ($urandom_range(0, 299) == 0) begin
        HRESETn = 1'b1;
        step();
        HRESETn = 1'b0;
        model_reset();
      end else begin
        #1;
        for (int k = 0; k < 2; k++) begin
          model_cycle(k, e);
          n_cmp++; if (o_htrans[k] !== e.htrans || o_haddr[k] !== e.haddr) begin n_err++;
            $display("FAIL rnd_addr[%0d] cyc %0d: got %h/%h want %h/%h", k, cyc, o_htrans[k],
                     o_haddr[k], e.htrans, e.haddr); end
          n_cmp++; if (o_hwrite[k] !== e.hwrite || o_hsize[k] !== e.hsize) begin n_err++;
            $display("FAIL rnd_ctrl[%0d] cyc %0d: got %b/%h want %b/%h", k, cyc, o_hwrite[k],
                     o_hsize[k], e.hwrite, e.hsize); end
          n_cmp++; if (o_m0_hready[k] !== e.rdy0 || o_m1_hready[k] !== e.rdy1) begin n_err++;
            $display("FAIL rnd_hready[%0d] cyc %0d: got %b%b want %b%b", k, cyc,
                     o_m0_hready[k], o_m1_hready[k], e.rdy0, e.rdy1); end
          if (e.hwdata_chk) begin
            n_cmp++; if (o_hwdata[k] !== e.hwdata) begin n_err++;
              $display("FAIL rnd_hwdata[%0d] cyc %0d: got %h want %h", k, cyc, o_hwdata[k],
                       e.hwdata); end
          end
          n_cmp++; if (o_m0_hrdata[k] !== hrdata || o_m1_hrdata[k] !== hrdata) begin n_err++;
            $display("FAIL rnd_hrdata[%0d] cyc %0d: got %h/%h want %h", k, cyc,
                     o_m0_hrdata[k], o_m1_hrdata[k], hrdata); end
        end
        step();
      end
    end
  endtask

  initial begin
    HRESETn = 1'b1;
    idle_inputs();
    hready = 1'b1;
    hrdata = '0;
    model_reset();
    test_reset();
    test_single();
    test_collision();
    test_rr_alternate();
    test_stall();
    test_wdata();
    test_reset_mid_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
